// File: rtl/axis_vote_join_ctrl_pkg.sv
// Shared types and constants for the three-lane vote/join controller.
package vote_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_ALL, VOTE, OUT} state_t;

  localparam int NUM_LANES      = 3;
  localparam int TUSER_NOMAJ    = 0;
  localparam int TUSER_DEGRADED = 1;
  localparam int SKIP_W         = 4;
  localparam logic [SKIP_W-1:0] SKIP_MAX = '1;
endpackage

// File: rtl/axis_lane_fifo.sv
// Per-lane result FIFO (tdata+tlast); a pushed word becomes visible at the head one cycle later.
// Callers gate push with !full and pop with !empty; simultaneous push and pop are supported.
module axis_lane_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end
endmodule

// File: rtl/axis_vote_join_ctrl.sv
// Aligns three classifier result lanes and issues one majority vote per sample (degraded on timeout).
// Result appears 2 cycles after all heads are present; the output is held under m_axis_tready backpressure.
module axis_vote_join_ctrl
  import vote_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
  input  logic                  s_axis_tvalid_0,
  output logic                  s_axis_tready_0,
  input  logic                  s_axis_tlast_0,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic                  s_axis_tvalid_1,
  output logic                  s_axis_tready_1,
  input  logic                  s_axis_tlast_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic                  s_axis_tvalid_2,
  output logic                  s_axis_tready_2,
  input  logic                  s_axis_tlast_2,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [1:0]            m_axis_tuser,
  input  logic                  clear_stats,
  output logic                  err_tlast_mismatch,
  output logic [15:0]           timeout_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    deg_q, deg_d;
  logic [SKIP_W-1:0]       skip_q [NUM_LANES];
  logic [SKIP_W-1:0]       skip_d [NUM_LANES];
  logic [15:0]             tcount_q, tcount_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [1:0]              tuser_q, tuser_d;

  logic [DATA_WIDTH-1:0]   in_dat [NUM_LANES];
  logic [DATA_WIDTH:0]     head_word [NUM_LANES];
  logic [DATA_WIDTH-1:0]   hd [NUM_LANES];
  logic [NUM_LANES-1:0]    in_vld, in_last, full, empty, pop, pop_vote;
  logic [NUM_LANES-1:0]    head_ok, head_last, skip_pop, skip_inc;
  logic [DATA_WIDTH-1:0]   vote_dat, pa, pb;
  logic                    vote_nomaj, pair, last_and, last_or, err;

  assign in_dat[0] = s_axis_tdata_0;
  assign in_dat[1] = s_axis_tdata_1;
  assign in_dat[2] = s_axis_tdata_2;
  assign in_vld    = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
  assign in_last   = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
  assign s_axis_tready_0 = !full[0];
  assign s_axis_tready_1 = !full[1];
  assign s_axis_tready_2 = !full[2];

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    axis_lane_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (in_vld[k] && !full[k]),
      .push_dat ({in_last[k], in_dat[k]}),
      .pop      (pop[k]),
      .full     (full[k]),
      .empty    (empty[k]),
      .head_dat (head_word[k])
    );
    assign hd[k]        = head_word[k][DATA_WIDTH-1:0];
    assign head_last[k] = head_word[k][DATA_WIDTH];
    // A pending skip consumes the late result of a lane that missed a degraded vote.
    assign head_ok[k]   = !empty[k] && (skip_q[k] == '0);
    assign skip_pop[k]  = !empty[k] && (skip_q[k] != '0);
    assign skip_inc[k]  = (state_q == VOTE) && deg_q && !head_ok[k];
    assign pop[k]       = pop_vote[k] | skip_pop[k];
  end

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      skip_d[k] = skip_q[k];
      if (skip_inc[k] && !skip_pop[k]) begin
        if (skip_q[k] != SKIP_MAX) skip_d[k] = skip_q[k] + 1'b1;
      end else if (skip_pop[k] && !skip_inc[k]) begin
        skip_d[k] = skip_q[k] - 1'b1;
      end
    end
  end

  always_comb begin
    vote_dat   = hd[0];
    vote_nomaj = 1'b0;
    pa         = hd[0];
    pb         = hd[0];
    pair       = 1'b0;
    case (head_ok)
      3'b111: begin
        if (hd[0] == hd[1] || hd[0] == hd[2]) vote_dat = hd[0];
        else if (hd[1] == hd[2])              vote_dat = hd[1];
        else                                  vote_nomaj = 1'b1;
      end
      3'b011:  begin pa = hd[0]; pb = hd[1]; pair = 1'b1; end
      3'b101:  begin pa = hd[0]; pb = hd[2]; pair = 1'b1; end
      3'b110:  begin pa = hd[1]; pb = hd[2]; pair = 1'b1; end
      3'b010:  vote_dat = hd[1];
      3'b100:  vote_dat = hd[2];
      default: vote_dat = hd[0];
    endcase
    if (pair) begin
      vote_dat   = pa;
      vote_nomaj = (pa != pb);
    end
  end

  assign last_and = &(head_last | ~head_ok);
  assign last_or  = |(head_last & head_ok);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    deg_d    = deg_q;
    pop_vote = '0;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (&head_ok) begin
          state_d = VOTE;
          deg_d   = 1'b0;
        end else if (|head_ok) begin
          state_d = WAIT_ALL;
          timer_d = TW'(1);
        end
      end
      WAIT_ALL: begin
        if (&head_ok) begin
          state_d = VOTE;
          deg_d   = 1'b0;
        end else if (timer_q == TW'(TIMEOUT_CYCLES)) begin
          state_d = VOTE;
          deg_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      VOTE: begin
        pop_vote                 = head_ok;
        tvalid_d                 = 1'b1;
        tdata_d                  = vote_dat;
        tlast_d                  = last_and;
        tuser_d                  = '0;
        tuser_d[TUSER_NOMAJ]     = vote_nomaj;
        tuser_d[TUSER_DEGRADED]  = deg_q;
        err                      = (last_and != last_or);
        state_d                  = OUT;
      end
      OUT: begin
        if (m_axis_tready) begin
          tvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear takes priority over a coinciding degraded-vote increment.
  always_comb begin
    tcount_d = tcount_q;
    if (clear_stats) tcount_d = '0;
    else if ((state_q == VOTE) && deg_q && (tcount_q != 16'hFFFF)) tcount_d = tcount_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      deg_q    <= 1'b0;
      tcount_q <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
      for (int k = 0; k < NUM_LANES; k++) skip_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      deg_q    <= deg_d;
      tcount_q <= tcount_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      for (int k = 0; k < NUM_LANES; k++) skip_q[k] <= skip_d[k];
    end
  end

  assign m_axis_tdata       = tdata_q;
  assign m_axis_tvalid      = tvalid_q;
  assign m_axis_tlast       = tlast_q;
  assign m_axis_tuser       = tuser_q;
  assign err_tlast_mismatch = err;
  assign timeout_count      = tcount_q;
endmodule

// File: tb/tb_axis_vote_join_ctrl.sv
// Directed plus randomized bench for axis_vote_join_ctrl against a per-sample vote model.
module tb_axis_vote_join_ctrl;
  localparam int DW  = 32;
  localparam int TO  = 8;

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
    logic [1:0]  user;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata_0 = '0, s_axis_tdata_1 = '0, s_axis_tdata_2 = '0;
  logic          s_axis_tvalid_0 = 1'b0, s_axis_tvalid_1 = 1'b0, s_axis_tvalid_2 = 1'b0;
  logic          s_axis_tlast_0 = 1'b0, s_axis_tlast_1 = 1'b0, s_axis_tlast_2 = 1'b0;
  logic          s_axis_tready_0, s_axis_tready_1, s_axis_tready_2;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [1:0]    m_axis_tuser;
  logic          clear_stats = 1'b0;
  logic          err_tlast_mismatch;
  logic [15:0]   timeout_count;

  int   total = 0;
  int   bad = 0;
  int   err_pulses = 0;
  int   exp_err = 0;
  bit   ready_mode = 1'b0;
  bit   ready_val = 1'b1;
  res_t exp_q[$];
  res_t got_q[$];

  axis_vote_join_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata_0(s_axis_tdata_0), .s_axis_tvalid_0(s_axis_tvalid_0),
    .s_axis_tready_0(s_axis_tready_0), .s_axis_tlast_0(s_axis_tlast_0),
    .s_axis_tdata_1(s_axis_tdata_1), .s_axis_tvalid_1(s_axis_tvalid_1),
    .s_axis_tready_1(s_axis_tready_1), .s_axis_tlast_1(s_axis_tlast_1),
    .s_axis_tdata_2(s_axis_tdata_2), .s_axis_tvalid_2(s_axis_tvalid_2),
    .s_axis_tready_2(s_axis_tready_2), .s_axis_tlast_2(s_axis_tlast_2),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .clear_stats(clear_stats),
    .err_tlast_mismatch(err_tlast_mismatch), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: the value seen at least twice among participating lanes wins, else the first one.
  function automatic res_t model(input logic [2:0] mask, input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [2:0] l);
    logic [31:0] dd [3];
    logic [31:0] v[$];
    res_t r;
    int   cnt;
    bit   found;
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    for (int k = 0; k < 3; k++) if (mask[k]) v.push_back(dd[k]);
    r.dat = v[0];
    found = 1'b0;
    foreach (v[i]) begin
      if (!found) begin
        cnt = 0;
        foreach (v[j]) if (v[j] == v[i]) cnt++;
        if (cnt >= 2) begin
          r.dat = v[i];
          found = 1'b1;
        end
      end
    end
    r.user[0] = (v.size() > 1) && !found;
    r.user[1] = (v.size() < 3);
    r.last    = &(l | ~mask);
    return r;
  endfunction

  // m_axis_tready driver: fixed value or random per cycle.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #2;
      m_axis_tready = ready_mode ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Output monitor: collects handshakes, counts mismatch pulses, checks hold stability.
  initial begin
    res_t cur, hold_r;
    bit   hold_v;
    hold_v = 1'b0;
    hold_r = '0;
    forever begin
      @(negedge clk);
      cur = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) chk("hold_stable", 64'({m_axis_tvalid, cur}), 64'({1'b1, hold_r}));
        if (err_tlast_mismatch) err_pulses++;
        if (m_axis_tvalid && m_axis_tready) got_q.push_back(cur);
        hold_v = m_axis_tvalid && !m_axis_tready;
        hold_r = cur;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [2:0] mask, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [2:0] l);
    logic [2:0] pend, acc;
    int n;
    s_axis_tdata_0 = d0; s_axis_tdata_1 = d1; s_axis_tdata_2 = d2;
    s_axis_tlast_0 = l[0]; s_axis_tlast_1 = l[1]; s_axis_tlast_2 = l[2];
    pend = mask;
    n = 0;
    while (pend != 3'b000 && n < 300) begin
      s_axis_tvalid_0 = pend[0]; s_axis_tvalid_1 = pend[1]; s_axis_tvalid_2 = pend[2];
      acc = pend & {s_axis_tready_2, s_axis_tready_1, s_axis_tready_0};
      @(posedge clk); #1;
      pend = pend & ~acc;
      n++;
    end
    s_axis_tvalid_0 = 1'b0; s_axis_tvalid_1 = 1'b0; s_axis_tvalid_2 = 1'b0;
    chk("send_accept", 64'(pend), 64'(0));
  endtask

  task automatic sample(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [2:0] l);
    exp_q.push_back(model(3'b111, d0, d1, d2, l));
    if ((|l) != (&l)) exp_err++;
    send(3'b111, d0, d1, d2, l);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (12) @(posedge clk);
    #1;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_err_pulses"}, 64'(err_pulses), 64'(exp_err));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_tvalid(input string tag, output int n);
    n = 0;
    while (!m_axis_tvalid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(m_axis_tvalid), 64'(1));
  endtask

  initial begin
    int n;
    logic [2:0] l;
    logic [31:0] a, b, c;

    // Reset state, during and after reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_treadys", 64'({s_axis_tready_2, s_axis_tready_1, s_axis_tready_0}), 64'(3'b111));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_outputs", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, err_tlast_mismatch}), 64'(0));
    chk("idle_tcount", 64'(timeout_count), 64'(0));

    // All three heads present: result 2 cycles later.
    sample(7, 7, 3, 3'b000);
    chk("t1_tvalid_c0", 64'(m_axis_tvalid), 64'(0));
    @(posedge clk); #1;
    chk("t1_tvalid_c1", 64'(m_axis_tvalid), 64'(0));
    @(posedge clk); #1;
    chk("t1_result", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tuser}), 64'({1'b1, 32'd7, 2'b00}));
    drain("t1");

    sample(1, 2, 3, 3'b000);
    sample(5, 9, 9, 3'b111);
    drain("t2");

    // Randomized back-to-back samples with random downstream backpressure.
    ready_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      l = 3'($urandom_range(0, 7));
      sample(a, b, c, l);
    end
    ready_mode = 1'b0;
    ready_val  = 1'b1;
    drain("rand");

    // Lane 2 silent: degraded vote after the timeout, then its late result is dropped.
    exp_q.push_back(model(3'b011, 4, 4, 0, 3'b011));
    send(3'b011, 4, 4, 0, 3'b011);
    wait_tvalid("t3_tvalid", n);
    chk("t3_latency", 64'(n), 64'(TO + 2));
    chk("t3_result", 64'({m_axis_tdata, m_axis_tuser}), 64'({32'd4, 2'b10}));
    @(posedge clk); #1;
    chk("t3_tcount", 64'(timeout_count), 64'(1));
    drain("t3");
    send(3'b100, 0, 0, 6, 3'b100);
    drain("t3_late");
    sample(5, 5, 5, 3'b111);
    drain("t3_realign");
    clear_stats = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    chk("clear_stats", 64'(timeout_count), 64'(0));

    // Downstream stalled while 6 samples are offered.
    ready_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 6; i++) sample(10 + i, 10 + i, 20 + i, 3'b111);
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("t4_treadys", 64'({s_axis_tready_2, s_axis_tready_1, s_axis_tready_0}), 64'(0));
        chk("t4_held", 64'({m_axis_tvalid, m_axis_tdata}), 64'({1'b1, 32'd10}));
        ready_val = 1'b1;
      end
    join
    drain("t4");

    // Mixed tlast: AND on the output, one-cycle mismatch pulse in the vote cycle.
    sample(8, 8, 8, 3'b011);
    chk("t5_err_c0", 64'(err_tlast_mismatch), 64'(0));
    @(posedge clk); #1;
    chk("t5_err_vote", 64'(err_tlast_mismatch), 64'(1));
    @(posedge clk); #1;
    chk("t5_out", 64'({err_tlast_mismatch, m_axis_tvalid, m_axis_tlast}), 64'(3'b010));
    drain("t5");

    // Reset while waiting on a lane.
    send(3'b011, 4, 4, 0, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6a_outputs", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}), 64'(0));
    chk("t6a_treadys", 64'({s_axis_tready_2, s_axis_tready_1, s_axis_tready_0}), 64'(3'b111));
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    drain("t6a");

    // Reset while holding a result under backpressure.
    ready_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(3'b111, 1, 1, 1, 3'b000);
    wait_tvalid("t6b_tvalid", n);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6b_outputs", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}), 64'(0));
    rst_n = 1'b1;
    ready_val = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    drain("t6b");
    sample(2, 3, 2, 3'b111);
    drain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
